circuit_sweep_ctrl: RTL and testbench

//  Sequencer/checker for the 3-input basic circuit (d = a&b | ~c, e = ~c).

---
 rtl/circuit_sweep_ctrl_if.sv | 35 +++
 rtl/circuit_sweep_ctrl.sv | 120 ++++++++++++
 tb/tb_circuit_sweep_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/circuit_sweep_ctrl_if.sv
// circuit_sweep_ctrl_if: bus between the sweep controller and the test harness that hosts the models
// Signals:
//   start, abort        sweep control requests (harness -> controller)
//   abc                 vector {a,b,c} presented to every model
//   dut_d, dut_e        per-model d/e responses (bit i = model i)
//   busy, done, pass    sweep progress and verdict
//   mis_cnt             saturating count of vectors with at least one failing model
//   first_fail_vec/_valid  first vector that mismatched and its qualifier
//   fail_mask           sticky per-model failure flags
// Modports: master = harness side, slave = controller side.
interface circuit_sweep_ctrl_if #(
   parameter int NUM_DUT = 3,
   parameter int CNT_W   = 4
);
   logic               start;
   logic               abort;
   logic [2:0]         abc;
   logic [NUM_DUT-1:0] dut_d;
   logic [NUM_DUT-1:0] dut_e;
   logic               busy;
   logic               done;
   logic               pass;
   logic [CNT_W-1:0]   mis_cnt;
   logic [2:0]         first_fail_vec;
   logic               first_fail_valid;
   logic [NUM_DUT-1:0] fail_mask;
   modport master (
      output start, abort, dut_d, dut_e,
      input  abc, busy, done, pass, mis_cnt, first_fail_vec, first_fail_valid, fail_mask
   );
   modport slave (
      input  start, abort, dut_d, dut_e,
      output abc, busy, done, pass, mis_cnt, first_fail_vec, first_fail_valid, fail_mask
   );
endinterface

// File: rtl/circuit_sweep_ctrl.sv
// circuit_sweep_ctrl: sweeps all 8 {a,b,c} vectors into NUM_DUT models of d = a&b | ~c, e = ~c and grades them
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   circuit_sweep_ctrl_if.slave: start/abort in, abc out, dut_d/dut_e in,
//         busy/done/pass/mis_cnt/first_fail_vec/first_fail_valid/fail_mask out
// Each vector spends one DRIVE cycle, SETTLE_CYCLES settle cycles and one CHECK cycle.
module circuit_sweep_ctrl #(
   parameter int SETTLE_CYCLES = 2,
   parameter int NUM_DUT       = 3,
   parameter int CNT_W         = 4
) (
   input logic                 clk,
   input logic                 rst,
   circuit_sweep_ctrl_if.slave bus
);
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_DRIVE  = 3'd1;
   localparam logic [2:0] S_SETTLE = 3'd2;
   localparam logic [2:0] S_CHECK  = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;
   // counter counts down to zero, so SETTLE lasts load+1 cycles
   localparam logic [3:0] SETTLE_LD = (SETTLE_CYCLES == 0) ? 4'd0 : 4'(SETTLE_CYCLES - 1);
   logic [2:0]         state_q, state_d;
   logic [2:0]         vec_q, vec_d;
   logic [2:0]         abc_q, abc_d;
   logic [3:0]         cnt_q, cnt_d;
   logic               pass_q, pass_d;
   logic [CNT_W-1:0]   mis_q, mis_d;
   logic [2:0]         ffv_q, ffv_d;
   logic               ffok_q, ffok_d;
   logic [NUM_DUT-1:0] mask_q, mask_d;
   logic [NUM_DUT-1:0] fail;
   logic               gd, ge, active;
   assign gd     = (abc_q[2] & abc_q[1]) | ~abc_q[0];
   assign ge     = ~abc_q[0];
   assign fail   = (bus.dut_d ^ {NUM_DUT{gd}}) | (bus.dut_e ^ {NUM_DUT{ge}});
   assign active = (state_q == S_DRIVE) || (state_q == S_SETTLE) || (state_q == S_CHECK);
   always_comb begin
      state_d = state_q;
      vec_d   = vec_q;
      abc_d   = abc_q;
      cnt_d   = cnt_q;
      pass_d  = pass_q;
      mis_d   = mis_q;
      ffv_d   = ffv_q;
      ffok_d  = ffok_q;
      mask_d  = mask_q;
      // abort beats any in-flight step, including the CHECK it lands on
      if (active && bus.abort) begin
         state_d = S_IDLE;
         pass_d  = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: if (bus.start && !bus.abort) begin
               state_d = S_DRIVE;
               vec_d   = 3'd0;
               pass_d  = 1'b0;
               mis_d   = '0;
               ffv_d   = 3'd0;
               ffok_d  = 1'b0;
               mask_d  = '0;
            end
            S_DRIVE: begin
               abc_d   = vec_q;
               cnt_d   = SETTLE_LD;
               state_d = (SETTLE_CYCLES == 0) ? S_CHECK : S_SETTLE;
            end
            S_SETTLE: begin
               cnt_d   = (cnt_q == 4'd0) ? cnt_q : cnt_q - 4'd1;
               state_d = (cnt_q == 4'd0) ? S_CHECK : S_SETTLE;
            end
            S_CHECK: begin
               mask_d  = mask_q | fail;
               mis_d   = (|fail && !(&mis_q)) ? mis_q + CNT_W'(1) : mis_q;
               ffv_d   = (|fail && !ffok_q) ? abc_q : ffv_q;
               ffok_d  = ffok_q | (|fail);
               vec_d   = vec_q + 3'd1;
               state_d = (vec_q == 3'd7) ? S_DONE : S_DRIVE;
            end
            S_DONE: begin
               pass_d  = (mis_q == '0);
               state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         vec_q   <= 3'd0;
         abc_q   <= 3'd0;
         cnt_q   <= 4'd0;
         pass_q  <= 1'b0;
         mis_q   <= '0;
         ffv_q   <= 3'd0;
         ffok_q  <= 1'b0;
         mask_q  <= '0;
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         abc_q   <= abc_d;
         cnt_q   <= cnt_d;
         pass_q  <= pass_d;
         mis_q   <= mis_d;
         ffv_q   <= ffv_d;
         ffok_q  <= ffok_d;
         mask_q  <= mask_d;
      end
   end
   assign bus.abc              = abc_q;
   assign bus.busy             = active;
   assign bus.done             = (state_q == S_DONE);
   assign bus.pass             = pass_q;
   assign bus.mis_cnt          = mis_q;
   assign bus.first_fail_vec   = ffv_q;
   assign bus.first_fail_valid = ffok_q;
   assign bus.fail_mask        = mask_q;
endmodule

// File: tb/tb_circuit_sweep_ctrl.sv
// tb_circuit_sweep_ctrl: directed and random sweeps of two controller configurations against a sweep-level reference
module tb_circuit_sweep_ctrl;
   logic clk = 1'b0;
   logic rst, st, ab;
   int   sel;
   int   total = 0;
   int   bad   = 0;
   int   n, cnt, ecnt, effv, eok, emask;
   always #5 clk = ~clk;
   circuit_sweep_ctrl_if #(.NUM_DUT(3), .CNT_W(4)) b0 ();
   circuit_sweep_ctrl_if #(.NUM_DUT(3), .CNT_W(2)) b1 ();
   circuit_sweep_ctrl #(.SETTLE_CYCLES(2), .NUM_DUT(3), .CNT_W(4)) u0 (.clk(clk), .rst(rst), .bus(b0.slave));
   circuit_sweep_ctrl #(.SETTLE_CYCLES(0), .NUM_DUT(3), .CNT_W(2)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));
   // per vector, per model: force enable and forced {d,e}; unforced models answer correctly
   logic [7:0][2:0]      fe0, fe1;
   logic [7:0][2:0][1:0] fv0, fv1;
   logic [2:0] d0, e0, d1, e1;
   function automatic logic [1:0] gold(input logic [2:0] v);
      return {(v[2] & v[1]) | ~v[0], ~v[0]};
   endfunction
   always_comb begin
      d0 = '0;
      e0 = '0;
      d1 = '0;
      e1 = '0;
      for (int i = 0; i < 3; i++) begin
         {d0[i], e0[i]} = fe0[b0.abc][i] ? fv0[b0.abc][i] : gold(b0.abc);
         {d1[i], e1[i]} = fe1[b1.abc][i] ? fv1[b1.abc][i] : gold(b1.abc);
      end
   end
   assign b0.dut_d = d0;
   assign b0.dut_e = e0;
   assign b1.dut_d = d1;
   assign b1.dut_e = e1;
   assign b0.start = st & (sel == 0);
   assign b1.start = st & (sel == 1);
   assign b0.abort = ab & (sel == 0);
   assign b1.abort = ab & (sel == 1);
   logic [2:0] o_abc, o_ffv, o_mask;
   logic [3:0] o_mis;
   logic       o_busy, o_done, o_pass, o_ffok;
   always_comb begin
      o_abc  = (sel == 1) ? b1.abc : b0.abc;
      o_ffv  = (sel == 1) ? b1.first_fail_vec : b0.first_fail_vec;
      o_mask = (sel == 1) ? b1.fail_mask : b0.fail_mask;
      o_mis  = (sel == 1) ? {2'b00, b1.mis_cnt} : b0.mis_cnt;
      o_busy = (sel == 1) ? b1.busy : b0.busy;
      o_done = (sel == 1) ? b1.done : b0.done;
      o_pass = (sel == 1) ? b1.pass : b0.pass;
      o_ffok = (sel == 1) ? b1.first_fail_valid : b0.first_fail_valid;
   end
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   // whole-sweep verdict straight from the rules: grade each of the 8 vectors in turn
   task automatic ref_sweep(input logic [7:0][2:0] fe, input logic [7:0][2:0][1:0] fv, input int maxc,
                            output int c, output int ffv, output int ok, output int mask);
      c = 0; ffv = 0; ok = 0; mask = 0;
      for (int v = 0; v < 8; v++) begin
         int any = 0;
         for (int i = 0; i < 3; i++)
            if (fe[v][i] && fv[v][i] != gold(3'(v))) begin
               any = 1;
               mask |= (1 << i);
            end
         if (any) begin
            if (c < maxc) c++;
            if (!ok) begin ffv = v; ok = 1; end
         end
      end
   endtask
   task automatic all_zero(input string tag);
      chk({tag, "_abc"}, o_abc, 0);
      chk({tag, "_busy"}, o_busy, 0);
      chk({tag, "_done"}, o_done, 0);
      chk({tag, "_pass"}, o_pass, 0);
      chk({tag, "_mis"}, o_mis, 0);
      chk({tag, "_ffv"}, o_ffv, 0);
      chk({tag, "_ffok"}, o_ffok, 0);
      chk({tag, "_mask"}, o_mask, 0);
   endtask
   // start a sweep; n = clock edges after the start-sampling edge; stops at done, abort or reset
   task automatic run(input int s, input int abort_at, input int rst_at, input int restart_at, output int nn);
      st = 1'b1;
      tick;
      st = 1'b0;
      nn = 0;
      while (!o_done && nn < 400) begin
         if (nn < 8 * (s + 2) && nn % (s + 2) == s + 1) chk("abc_at_check", o_abc, nn / (s + 2));
         st  = (nn == restart_at);
         ab  = (nn == abort_at);
         rst = (nn == rst_at);
         tick;
         st = 1'b0;
         ab = 1'b0;
         rst = 1'b0;
         if (nn == abort_at || nn == rst_at) begin nn++; break; end
         nn++;
      end
   endtask
   task automatic finish_check(input string tag, input int s, input int maxc, input logic abort_in_done, input int nn);
      ref_sweep((sel == 1) ? fe1 : fe0, (sel == 1) ? fv1 : fv0, maxc, ecnt, effv, eok, emask);
      chk({tag, "_latency"}, nn, 8 * (s + 2));
      chk({tag, "_done"}, o_done, 1);
      chk({tag, "_busy_in_done"}, o_busy, 0);
      ab = abort_in_done;
      tick;
      ab = 1'b0;
      chk({tag, "_done_pulse"}, o_done, 0);
      chk({tag, "_pass"}, o_pass, (ecnt == 0));
      chk({tag, "_mis"}, o_mis, ecnt);
      chk({tag, "_ffv"}, o_ffv, effv);
      chk({tag, "_ffok"}, o_ffok, eok);
      chk({tag, "_mask"}, o_mask, emask);
      chk({tag, "_abc_hold"}, o_abc, 7);
   endtask
   initial begin
      rst = 1'b1; st = 1'b0; ab = 1'b0; sel = 0;
      fe0 = '0; fv0 = '0; fe1 = '0; fv1 = '0;
      repeat (3) tick;
      rst = 1'b0;
      all_zero("reset");
      // golden models; abort in DONE must not suppress the pulse or verdict
      run(2, -1, -1, -1, n);
      finish_check("golden", 2, 15, 1'b1, n);
      // model 2 latched at {d,e}=11 from vector 3 on
      for (int v = 3; v < 8; v++) begin
         fe0[v][2] = 1'b1;
         fv0[v][2] = 2'b11;
      end
      run(2, -1, -1, -1, n);
      finish_check("latched", 2, 15, 1'b0, n);
      chk("latched_mis_const", o_mis, 3);
      chk("latched_ffv_const", o_ffv, 3);
      chk("latched_mask_const", o_mask, 3'b100);
      // abort during CHECK of vector 4
      fe0 = '0;
      run(2, 19, -1, -1, n);
      chk("abort_busy", o_busy, 0);
      chk("abort_done", o_done, 0);
      chk("abort_pass", o_pass, 0);
      chk("abort_abc", o_abc, 4);
      cnt = 0;
      repeat (40) begin
         tick;
         if (o_done) cnt++;
      end
      chk("abort_no_done", cnt, 0);
      chk("abort_abc_hold", o_abc, 4);
      // start while busy is ignored; start+abort in IDLE is ignored
      run(2, -1, -1, 10, n);
      finish_check("restart", 2, 15, 1'b0, n);
      st = 1'b1; ab = 1'b1;
      tick;
      st = 1'b0; ab = 1'b0;
      chk("start_abort_busy", o_busy, 0);
      tick;
      chk("start_abort_busy2", o_busy, 0);
      chk("start_abort_pass_hold", o_pass, 1);
      // reset during SETTLE of vector 5 after vector 0 failed everywhere
      fe0[0] = 3'b111;
      fv0[0] = '0;
      run(2, -1, 21, -1, n);
      all_zero("midreset");
      fe0 = '0;
      run(2, -1, -1, -1, n);
      finish_check("after_reset", 2, 15, 1'b0, n);
      repeat (6) begin
         fe0 = 24'($urandom & $urandom);
         fv0 = 48'({$urandom, $urandom});
         run(2, -1, -1, -1, n);
         finish_check("rand0", 2, 15, 1'($urandom), n);
      end
      // narrow counter, zero settle: every model stuck at 00
      sel = 1;
      fe1 = '1;
      fv1 = '0;
      run(0, -1, -1, -1, n);
      finish_check("stuck00", 0, 3, 1'b0, n);
      chk("stuck00_mis_sat", o_mis, 3);
      chk("stuck00_ffv_const", o_ffv, 0);
      chk("stuck00_mask_const", o_mask, 3'b111);
      repeat (6) begin
         fe1 = 24'($urandom & $urandom);
         fv1 = 48'({$urandom, $urandom});
         run(0, -1, -1, -1, n);
         finish_check("rand1", 0, 3, 1'b0, n);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
